sync_down_timer: RTL

- Loadable synchronous down counter / interval timer. It counts toward zero, the opposite direction of the team's 4-bit synchronous up counter.
- Used wherever a block needs "N cycles then event": delay generation, timeouts, and periodic ticks in auto-reload mode.
- Single clock domain. Registered outputs only.

---
 rtl/sync_down_timer_if.sv | 33 +++
 rtl/sync_down_timer.sv | 66 ++++++
 2 files changed

// File: rtl/sync_down_timer_if.sv
// Port bundle for sync_down_timer: control/load inputs and count/status outputs.
// Signals: load, din, en, reload (master -> timer); q, busy, tc (timer -> master).
interface sync_down_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             en;
    logic             reload;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;

    modport master (
        output load,
        output din,
        output en,
        output reload,
        input  q,
        input  busy,
        input  tc
    );

    modport slave (
        input  load,
        input  din,
        input  en,
        input  reload,
        output q,
        output busy,
        output tc
    );
endinterface

// File: rtl/sync_down_timer.sv
// Loadable down counter / interval timer with one-shot and auto-reload modes.
// Ports: clk, rst (async active-low), bus (slave: load/din/en/reload in; q/busy/tc out).
module sync_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    sync_down_timer_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= ZERO;
            rld_q   <= ZERO;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            // A load restarts the count and never decrements on its own edge.
            cnt_d   = bus.din;
            rld_d   = bus.din;
            state_d = (bus.din != ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && bus.en) begin
            if (cnt_q > ONE) begin
                cnt_d = cnt_q - ONE;
            end else begin
                // Expiry: q==1 in RUN. reload is only consulted here.
                tc_d = 1'b1;
                if (bus.reload) begin
                    cnt_d = rld_q;
                end else begin
                    cnt_d   = ZERO;
                    state_d = IDLE;
                end
            end
        end
    end

    assign bus.q    = cnt_q;
    assign bus.busy = (state_q == RUN);
    assign bus.tc   = tc_q;
endmodule
